kronos_mem_responder: RTL and testbench

KRONOS_MEM_RESPONDER -- requirements
Module: kronos_mem_responder

---
 rtl/kronos_types.sv | 27 ++
 rtl/kronos_mem_port.sv | 63 ++++++
 rtl/kronos_mem_responder.sv | 132 +++++++++++++
 tb/tb_kronos_mem_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - shared port FSM states, timer window offsets and byte merge helper
package kronos_types;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_WAIT = 2'd1,
        PORT_ACK  = 2'd2
    } port_state_e;

    localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
    localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] TMR_MSIP        = 5'h10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/kronos_mem_port.sv
// rtl/kronos_mem_port.sv - per-port request FSM with wait-state counter and request latch
module kronos_mem_port
    import kronos_types::*;
#(
    parameter int WS = 0,
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          req,
    input  logic [PW-1:0] payload,
    output logic          fire,
    output logic          ack,
    output logic [PW-1:0] eff_payload
);

    localparam int CW = (WS > 1) ? $clog2(WS + 1) : 1;

    port_state_e   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [PW-1:0] held;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state <= PORT_IDLE;
            cnt   <= '0;
            held  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == PORT_IDLE && req) held <= payload;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            PORT_IDLE: begin
                if (req) begin
                    if (WS == 0) begin
                        state_nx = PORT_ACK;
                    end else begin
                        state_nx = PORT_WAIT;
                        cnt_nx   = CW'(WS);
                    end
                end
            end
            PORT_WAIT: begin
                if (cnt <= CW'(1)) state_nx = PORT_ACK;
                else               cnt_nx   = cnt - 1'b1;
            end
            PORT_ACK:  state_nx = PORT_IDLE;
            default:   state_nx = PORT_IDLE;
        endcase
    end

    // fire marks the edge that enters ACK; the top commits reads/writes on it
    assign fire        = rstz && (state_nx == PORT_ACK);
    assign ack         = (state == PORT_ACK);
    assign eff_payload = (state == PORT_IDLE) ? payload : held;

endmodule

// File: rtl/kronos_mem_responder.sv
// rtl/kronos_mem_responder.sv - dual-port word memory with timer/IRQ register window
module kronos_mem_responder
    import kronos_types::*;
#(
    parameter int          DEPTH    = 1024,
    parameter int          INSTR_WS = 0,
    parameter int          DATA_WS  = 1,
    parameter logic [31:0] TMR_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic        software_interrupt,
    output logic        timer_interrupt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

    logic [31:0] mem [DEPTH];

    logic        i_fire;
    logic [31:0] i_addr;
    logic        d_fire;
    logic [68:0] d_payload;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic        d_wr;

    kronos_mem_port #(.WS(INSTR_WS), .PW(32)) u_instr_port (
        .clk         (clk),
        .rstz        (rstz),
        .req         (instr_req),
        .payload     (instr_addr),
        .fire        (i_fire),
        .ack         (instr_ack),
        .eff_payload (i_addr)
    );

    kronos_mem_port #(.WS(DATA_WS), .PW(69)) u_data_port (
        .clk         (clk),
        .rstz        (rstz),
        .req         (data_req),
        .payload     ({data_addr, data_wr_data, data_mask, data_wr_en}),
        .fire        (d_fire),
        .ack         (data_ack),
        .eff_payload (d_payload)
    );

    assign {d_addr, d_wdata, d_mask, d_wr} = d_payload;

    logic          i_in_mem, d_in_mem, d_in_tmr;
    logic [AW-1:0] i_idx, d_idx;
    logic [31:0]   d_tmr_diff;
    logic [4:0]    d_tmr_off;
    logic [31:0]   d_rdata;
    logic [63:0]   mtime, mtimecmp;
    logic          msip;

    assign i_in_mem   = (i_addr < MEM_BYTES);
    assign i_idx      = i_addr[AW+1:2];
    assign d_in_mem   = (d_addr < MEM_BYTES);
    assign d_idx      = d_addr[AW+1:2];
    assign d_tmr_diff = d_addr - TMR_BASE;
    assign d_in_tmr   = !d_in_mem && (d_tmr_diff < 32'd32);
    assign d_tmr_off  = {d_tmr_diff[4:2], 2'b00};

    always_comb begin
        d_rdata = '0;
        if (d_in_mem) begin
            d_rdata = mem[d_idx];
        end else if (d_in_tmr) begin
            case (d_tmr_off)
                TMR_MTIME_LO:    d_rdata = mtime[31:0];
                TMR_MTIME_HI:    d_rdata = mtime[63:32];
                TMR_MTIMECMP_LO: d_rdata = mtimecmp[31:0];
                TMR_MTIMECMP_HI: d_rdata = mtimecmp[63:32];
                TMR_MSIP:        d_rdata = {31'b0, msip};
                default:         d_rdata = '0;
            endcase
        end
    end

    // memory has no reset; a store lands on the same edge the instr read samples, so fetch sees the old word
    always_ff @(posedge clk) begin
        if (d_fire && d_wr && d_in_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (d_mask[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            instr_data      <= '0;
            data_rd_data    <= '0;
            mtime           <= '0;
            mtimecmp        <= '1;
            msip            <= 1'b0;
            timer_interrupt <= 1'b0;
        end else begin
            if (i_fire)          instr_data   <= i_in_mem ? mem[i_idx] : '0;
            if (d_fire && !d_wr) data_rd_data <= d_rdata;
            mtime           <= mtime + 64'd1;
            timer_interrupt <= (mtime >= mtimecmp);
            // a written half replaces the increment for that half only
            if (d_fire && d_wr && d_in_tmr) begin
                case (d_tmr_off)
                    TMR_MTIME_LO:    mtime[31:0]     <= merge_bytes(mtime[31:0], d_wdata, d_mask);
                    TMR_MTIME_HI:    mtime[63:32]    <= merge_bytes(mtime[63:32], d_wdata, d_mask);
                    TMR_MTIMECMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], d_wdata, d_mask);
                    TMR_MTIMECMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], d_wdata, d_mask);
                    TMR_MSIP:        if (d_mask[0]) msip <= d_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    assign software_interrupt = msip;

endmodule

// File: tb/tb_kronos_mem_responder.sv
// tb/tb_kronos_mem_responder.sv - randomized bench with transaction-level memory/timer model
module tb_kronos_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          IWS   = 0;
    localparam int          DWS   = 1;
    localparam logic [31:0] TB    = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic [3:0]  data_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        data_req = 1'b0;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic        software_interrupt;
    logic        timer_interrupt;

    kronos_mem_responder #(.DEPTH(DEPTH), .INSTR_WS(IWS), .DATA_WS(DWS), .TMR_BASE(TB)) dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_ack(instr_ack),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_rd_data(data_rd_data), .data_ack(data_ack),
        .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; logic wr; int ack_cyc; } dtx_t;
    typedef struct { logic [31:0] addr; int ack_cyc; } itx_t;
    dtx_t dq[$];
    itx_t iq[$];

    logic [31:0] mm [DEPTH];
    logic [3:0]  mk [DEPTH];
    logic [63:0] m_time, m_cmp;
    logic        m_msip;
    logic [31:0] il_exp, dl_exp;
    bit          il_known, dl_known;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_mem(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic bit in_tmr(input logic [31:0] a);
        return !in_mem(a) && a >= TB && (a - TB) < 32'd32;
    endfunction

    task automatic model_read(input logic [31:0] a, input bit is_instr, output logic [31:0] v, output bit known);
        v = '0;
        known = 1'b1;
        if (in_mem(a)) begin
            v = mm[a >> 2];
            known = (mk[a >> 2] == 4'hF);
        end else if (!is_instr && in_tmr(a)) begin
            case ((a - TB) >> 2)
                32'd0: v = m_time[31:0];
                32'd1: v = m_time[63:32];
                32'd2: v = m_cmp[31:0];
                32'd3: v = m_cmp[63:32];
                32'd4: v = {31'b0, m_msip};
                default: v = '0;
            endcase
        end
    endtask

    task automatic compare_cycle();
        itx_t it;
        dtx_t dx;
        bit d_wr_now;
        logic [31:0] v;
        bit k;
        logic [63:0] pre_time;
        if (!rstz) begin
            iq.delete();
            dq.delete();
            m_time = '0; m_cmp = '1; m_msip = 1'b0;
            il_exp = '0; dl_exp = '0; il_known = 1'b1; dl_known = 1'b1;
            chk("rst_instr_ack", 64'(instr_ack), 64'd0);
            chk("rst_data_ack", 64'(data_ack), 64'd0);
            chk("rst_instr_data", 64'(instr_data), 64'd0);
            chk("rst_data_rd_data", 64'(data_rd_data), 64'd0);
            chk("rst_timer_irq", 64'(timer_interrupt), 64'd0);
            chk("rst_sw_irq", 64'(software_interrupt), 64'd0);
            return;
        end
        if (instr_ack) begin
            if (iq.size() == 0) chk("instr_spurious_ack", 64'd1, 64'd0);
            else begin
                it = iq.pop_front();
                chk("instr_ack_cycle", 64'(cyc), 64'(it.ack_cyc));
                model_read(it.addr, 1'b1, v, k);
                il_exp = v; il_known = k;
            end
        end else if (iq.size() != 0 && cyc > iq[0].ack_cyc) begin
            chk("instr_ack_late", 64'd0, 64'd1);
            void'(iq.pop_front());
        end
        if (il_known) chk("instr_data", 64'(instr_data), 64'(il_exp));

        d_wr_now = 1'b0;
        if (data_ack) begin
            if (dq.size() == 0) chk("data_spurious_ack", 64'd1, 64'd0);
            else begin
                dx = dq.pop_front();
                chk("data_ack_cycle", 64'(cyc), 64'(dx.ack_cyc));
                if (dx.wr) d_wr_now = 1'b1;
                else begin
                    model_read(dx.addr, 1'b0, v, k);
                    dl_exp = v; dl_known = k;
                end
            end
        end else if (dq.size() != 0 && cyc > dq[0].ack_cyc) begin
            chk("data_ack_late", 64'd0, 64'd1);
            void'(dq.pop_front());
        end
        if (dl_known) chk("data_rd_data", 64'(data_rd_data), 64'(dl_exp));

        chk("timer_interrupt", 64'(timer_interrupt), 64'(m_time >= m_cmp));
        pre_time = m_time;
        m_time = pre_time + 64'd1;
        if (d_wr_now) begin
            if (in_mem(dx.addr)) begin
                mm[dx.addr >> 2] = bmerge(mm[dx.addr >> 2], dx.wdata, dx.mask);
                mk[dx.addr >> 2] = mk[dx.addr >> 2] | dx.mask;
            end else if (in_tmr(dx.addr)) begin
                case ((dx.addr - TB) >> 2)
                    32'd0: m_time[31:0]  = bmerge(pre_time[31:0], dx.wdata, dx.mask);
                    32'd1: m_time[63:32] = bmerge(pre_time[63:32], dx.wdata, dx.mask);
                    32'd2: m_cmp[31:0]   = bmerge(m_cmp[31:0], dx.wdata, dx.mask);
                    32'd3: m_cmp[63:32]  = bmerge(m_cmp[63:32], dx.wdata, dx.mask);
                    32'd4: if (dx.mask[0]) m_msip = dx.wdata[0];
                    default: ;
                endcase
            end
        end
        chk("software_interrupt", 64'(software_interrupt), 64'(m_msip));
    endtask

    always @(posedge clk) begin
        #1;
        compare_cycle();
    end

    // called at a negedge with the port idle; returns at a negedge with the port idle again
    task automatic data_txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m, input logic wr,
                            output logic [31:0] rd, output int lat);
        dtx_t t;
        int start;
        bit got;
        data_addr = a; data_wr_data = w; data_mask = m; data_wr_en = wr; data_req = 1'b1;
        start = cyc;
        t = '{a, w, m, wr, cyc + 1 + DWS};
        dq.push_back(t);
        @(negedge clk);
        data_req = 1'b0;
        data_addr = $urandom; data_wr_data = $urandom; data_mask = 4'($urandom); data_wr_en = 1'($urandom);
        got = 1'b0; rd = '0; lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (data_ack) begin got = 1'b1; rd = data_rd_data; lat = cyc - start; end
            else @(negedge clk);
        end
        if (!got) chk("data_ack_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic instr_txn(input logic [31:0] a, output logic [31:0] rd, output int lat);
        itx_t t;
        int start;
        bit got;
        instr_addr = a; instr_req = 1'b1;
        start = cyc;
        t = '{a, cyc + 1 + IWS};
        iq.push_back(t);
        @(negedge clk);
        instr_req = 1'b0;
        instr_addr = $urandom;
        got = 1'b0; rd = '0; lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (instr_ack) begin got = 1'b1; rd = instr_data; lat = cyc - start; end
            else @(negedge clk);
        end
        if (!got) chk("instr_ack_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic instr_burst(input int n);
        itx_t t;
        int acks;
        int prev;
        instr_addr = 32'h10; instr_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            t = '{32'h10, cyc + 1 + k * (IWS + 2)};
            iq.push_back(t);
        end
        acks = 0; prev = -1;
        for (int i = 0; i < 60 && acks < n; i++) begin
            @(negedge clk);
            if (instr_ack) begin
                if (prev >= 0) chk("instr_b2b_spacing", 64'(cyc - prev), 64'd2);
                chk("instr_b2b_data", 64'(instr_data), 64'h0000_0000_CAFE_0004);
                prev = cyc;
                acks++;
            end
        end
        instr_req = 1'b0;
        if (acks != n) chk("instr_burst_timeout", 64'(acks), 64'(n));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_data_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return 32'($urandom_range(0, 127));
        else if (sel == 7) return 32'h0000_1000 + ($urandom & 32'h00FF_FFFF);
        else if (sel == 8) return TB + 32'($urandom_range(0, 31));
        else               return TB + 32'h20 + 32'($urandom_range(0, 63));
    endfunction

    function automatic logic [31:0] rand_instr_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 7)      return 32'($urandom_range(0, 127));
        else if (sel == 8) return TB + 32'($urandom_range(0, 31));
        else               return 32'h0000_2000 + 32'($urandom_range(0, 255));
    endfunction

    logic [31:0] rd, rd2;
    int          lat, lat2, s, ack_c, rise;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = '0; end
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        @(negedge clk);

        // back-to-back fetches of a held request
        data_txn(32'h10, 32'hCAFE_0004, 4'hF, 1'b1, rd, lat);
        instr_burst(4);
        instr_txn(32'h10, rd, lat);
        chk("instr_latency", 64'(lat), 64'd1);

        // masked store then load
        data_txn(32'h20, 32'h1122_3344, 4'hF, 1'b1, rd, lat);
        data_txn(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1, rd, lat);
        chk("store_latency", 64'(lat), 64'd2);
        data_txn(32'h20, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("masked_store_load", 64'(rd), 64'h0000_0000_11BB_33DD);

        // out-of-range access
        data_txn(32'h0000_5000, 32'h1234_5678, 4'hF, 1'b1, rd, lat);
        data_txn(32'h0000_5000, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("out_of_range_load", 64'(rd), 64'd0);

        // timer compare delay
        data_txn(TB + 32'h0, 32'h0, 4'hF, 1'b1, rd, lat);
        data_txn(TB + 32'hC, 32'h0, 4'hF, 1'b1, rd, lat);
        data_txn(TB + 32'h8, 32'h40, 4'hF, 1'b1, rd, lat);
        data_txn(TB + 32'h4, 32'h0, 4'hF, 1'b1, rd, lat);
        s = cyc;
        data_txn(TB + 32'h0, 32'h30, 4'hF, 1'b1, rd, lat);
        ack_c = s + lat;
        rise = -1;
        for (int i = 0; i < 40 && rise < 0; i++) begin
            if (timer_interrupt) rise = cyc - ack_c;
            else @(negedge clk);
        end
        chk("timer_irq_delay", 64'(rise), 64'd17);

        // software interrupt, then reset in the middle of a store
        data_txn(TB + 32'h10, 32'h1, 4'hF, 1'b1, rd, lat);
        chk("msip_set", 64'(software_interrupt), 64'd1);
        data_txn(32'h40, 32'h5A5A_1234, 4'hF, 1'b1, rd, lat);
        data_addr = 32'h40; data_wr_data = 32'hFFFF_FFFF; data_mask = 4'hF; data_wr_en = 1'b1; data_req = 1'b1;
        @(negedge clk);
        rstz = 1'b0; data_req = 1'b0;
        @(negedge clk);
        chk("reset_no_ack", 64'(data_ack), 64'd0);
        chk("reset_sw_irq", 64'(software_interrupt), 64'd0);
        chk("reset_timer_irq", 64'(timer_interrupt), 64'd0);
        rstz = 1'b1;
        @(negedge clk);
        data_txn(32'h40, 32'h0, 4'hF, 1'b0, rd, lat);
        chk("reset_drop_store", 64'(rd), 64'h0000_0000_5A5A_1234);
        data_txn(TB + 32'h10, 32'h1, 4'hF, 1'b1, rd, lat);
        data_txn(TB + 32'h10, 32'h0, 4'hF, 1'b1, rd, lat);
        chk("msip_clear", 64'(software_interrupt), 64'd0);

        // same-cycle store and fetch of one word
        data_txn(32'h8, 32'h0102_0304, 4'hF, 1'b1, rd, lat);
        fork
            data_txn(32'h8, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, lat);
            begin
                @(negedge clk);
                instr_txn(32'h8, rd2, lat2);
            end
        join
        chk("same_cycle_fetch_old", 64'(rd2), 64'h0000_0000_0102_0304);
        instr_txn(32'h8, rd2, lat2);
        chk("fetch_after_store", 64'(rd2), 64'h0000_0000_DEAD_BEEF);
        instr_txn(TB, rd2, lat2);
        chk("instr_timer_window", 64'(rd2), 64'd0);

        // concurrent randomized traffic on both ports
        fork
            begin
                logic [31:0] r;
                int l;
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    data_txn(rand_data_addr(), $urandom, 4'($urandom), 1'($urandom), r, l);
                end
            end
            begin
                logic [31:0] r;
                int l;
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    instr_txn(rand_instr_addr(), r, l);
                end
            end
        join

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
